// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the IF->ID decoupling queue.
package if_id_queue_pkg;

  localparam int IF_ID_DEPTH_DEFAULT = 2;

  localparam logic [31:0] INST_NOP = 32'h0000_0001;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [7:0]  INT_NONE = 8'h00;

  localparam int          HOLD_FLAG_W = 3;
  localparam logic [2:0]  Hold_None   = 3'b000;
  localparam logic [2:0]  Hold_If     = 3'b010;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [7:0]  int_flag;
  } if_id_entry_t;

  function automatic logic hold_blocks_if(input logic [HOLD_FLAG_W-1:0] hold_flag);
    return (hold_flag >= Hold_If);
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Queue storage: DEPTH-entry flop array, one write port, asynchronous read, no reset.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter  int DATA_W = $bits(if_id_entry_t),
  parameter  int DEPTH  = IF_ID_DEPTH_DEFAULT,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write the accepted entry into its slot
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue with valid/ready on both sides, hold and flush.
// Optional perf counters are built when IF_ID_PERF_EN is defined.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8,
  parameter int DEPTH  = IF_ID_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INST_W-1:0]      inst_i,
  input  logic [ADDR_W-1:0]      inst_addr_i,
  input  logic [INT_W-1:0]       int_flag_i,
  input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INST_W-1:0]      inst_o,
  output logic [ADDR_W-1:0]      inst_addr_o,
  output logic [INT_W-1:0]       int_flag_o,
  output logic [31:0]            bubble_cnt_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = INST_W + ADDR_W + INT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_hold_en;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign in_ready_o  = ~w_full;
  assign out_valid_o = ~w_empty;
  assign w_hold_en   = hold_blocks_if(hold_flag_i);
  assign w_push      = in_valid_i & in_ready_o & ~flush_i;
  assign w_pop       = out_valid_o & out_ready_i & ~w_hold_en & ~flush_i;
  assign w_wdata     = {inst_i, inst_addr_i, int_flag_i};

  if_id_queue_mem #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Head payload, forced to the idle encoding while the queue is empty
  always_comb begin
    inst_o      = INST_W'(INST_NOP);
    inst_addr_o = ADDR_W'(ZeroWord);
    int_flag_o  = INT_W'(INT_NONE);
    if (w_empty) begin
      inst_o      = INST_W'(INST_NOP);
      inst_addr_o = ADDR_W'(ZeroWord);
      int_flag_o  = INT_W'(INT_NONE);
    end else begin
      {inst_o, inst_addr_o, int_flag_o} = w_rdata;
    end
  end

  // Pointer and occupancy control; flush discards everything and rewinds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  // Decode-starved and fetch-blocked cycle counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= 32'h0;
      r_stall_cnt  <= 32'h0;
    end else begin
      if (~out_valid_o & ~w_hold_en & ~flush_i) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (in_valid_i & ~in_ready_o) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`else
  assign bubble_cnt_o = 32'h0;
  assign stall_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue (DEPTH=2); perf expectations follow IF_ID_PERF_EN.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [71:0] IDLE_HEAD = {32'h0000_0001, 32'h0, 8'h0};

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [7:0]  int_flag_i;
  logic [2:0]  hold_flag_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;
  logic [31:0] bubble_cnt_o;
  logic [31:0] stall_cnt_o;

  int          n_vec;
  int          n_err;
  logic [71:0] sb[$];
  logic        pop_seen;
  logic [71:0] pop_exp;
  logic [71:0] pop_obs;
  logic [71:0] exp_head;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .int_flag_i   (int_flag_i),
    .hold_flag_i  (hold_flag_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .int_flag_o   (int_flag_o),
    .bubble_cnt_o (bubble_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid_i  = 1'b0;
    inst_i      = 32'h0;
    inst_addr_i = 32'h0;
    int_flag_i  = 8'h0;
    hold_flag_i = Hold_If;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic release_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // One clock of stimulus; the scoreboard follows the queue rules independently of the DUT
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                       input logic [7:0] intf, input logic [2:0] hold, input logic fl,
                       input logic rdy);
    logic m_push;
    logic m_pop;
    in_valid_i  = v;
    inst_i      = inst;
    inst_addr_i = addr;
    int_flag_i  = intf;
    hold_flag_i = hold;
    flush_i     = fl;
    out_ready_i = rdy;
    m_push   = v && (sb.size() < DEPTH) && !fl;
    m_pop    = (sb.size() > 0) && rdy && (hold < Hold_If) && !fl;
    pop_seen = m_pop;
    if (m_pop) begin
      pop_exp = sb.pop_front();
      pop_obs = {inst_o, inst_addr_o, int_flag_o};
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (m_push) sb.push_back({inst, addr, intf});
    exp_head = (sb.size() == 0) ? IDLE_HEAD : sb[0];
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL reset_flags got v=%b r=%b want v=0 r=1", out_valid_o, in_ready_o);
    end
    n_vec++;
    if ({inst_o, inst_addr_o, int_flag_o} !== IDLE_HEAD) begin
      n_err++; $display("FAIL reset_payload got %h want %h", {inst_o, inst_addr_o, int_flag_o}, IDLE_HEAD);
    end
    n_vec++;
    if ({bubble_cnt_o, stall_cnt_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_perf got %0d/%0d want 0/0", bubble_cnt_o, stall_cnt_o);
    end
    cycle(1'b1, 32'h0000_0033, 32'h0000_0100, 8'h01, Hold_None, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid_o, in_ready_o, inst_o} !== {2'b01, 32'h0000_0001}) begin
      n_err++; $display("FAIL async_reset got v=%b r=%b inst=%h want v=0 r=1 inst=00000001",
                        out_valid_o, in_ready_o, inst_o);
    end
    sb.delete();
    release_reset();
  endtask

  task automatic test_fill();
    cycle(1'b1, 32'h0000_0013, 32'h0, 8'h00, Hold_None, 1'b0, 1'b0);
    cycle(1'b1, 32'h0010_0093, 32'h4, 8'h00, Hold_None, 1'b0, 1'b0);
    n_vec++;
    if ({in_ready_o, out_valid_o, inst_o, inst_addr_o} !== {2'b01, 32'h0000_0013, 32'h0}) begin
      n_err++; $display("FAIL fill_full got r=%b v=%b head=%h@%h want r=0 v=1 head=00000013@00000000",
                        in_ready_o, out_valid_o, inst_o, inst_addr_o);
    end
    cycle(1'b1, 32'hDEAD_BEEF, 32'h8, 8'h00, Hold_None, 1'b0, 1'b0);
    n_vec++;
    if ({inst_o, inst_addr_o, int_flag_o} !== exp_head) begin
      n_err++; $display("FAIL fill_blocked got %h want %h", {inst_o, inst_addr_o, int_flag_o}, exp_head);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_None, 1'b0, 1'b1);
      n_vec++;
      if (pop_seen && pop_obs !== pop_exp) begin
        n_err++; $display("FAIL fill_drain got %h want %h", pop_obs, pop_exp);
      end
    end
    n_vec++;
    if (out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL fill_empty got v=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 11; i++) begin
      cycle(i < 10, 32'h0000_1000 + 32'(i), 32'(i) * 32'd4, 8'(i), Hold_None, 1'b0, 1'b1);
      if (pop_seen) begin
        n_vec++;
        if (pop_obs !== pop_exp) begin
          n_err++; $display("FAIL stream_order[%0d] got %h want %h", i, pop_obs, pop_exp);
        end
      end
      if (i < 10) begin
        n_vec++;
        if ({out_valid_o, in_ready_o} !== 2'b11 || {inst_o, inst_addr_o, int_flag_o} !== exp_head) begin
          n_err++; $display("FAIL stream_head[%0d] got v=%b r=%b %h want v=1 r=1 %h", i,
                            out_valid_o, in_ready_o, {inst_o, inst_addr_o, int_flag_o}, exp_head);
        end
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 32'h0000_A001, 32'h0000_0200, 8'h11, Hold_None, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_A002, 32'h0000_0204, 8'h22, Hold_If, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_If, 1'b0, 1'b1);
    n_vec++;
    if ({out_valid_o, in_ready_o, inst_o, inst_addr_o, int_flag_o} !==
        {2'b10, 32'h0000_A001, 32'h0000_0200, 8'h11}) begin
      n_err++; $display("FAIL hold_frozen got v=%b r=%b %h want v=1 r=0 0000a001/00000200/11",
                        out_valid_o, in_ready_o, {inst_o, inst_addr_o, int_flag_o});
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_None, 1'b0, 1'b1);
      n_vec++;
      if (!pop_seen || pop_obs !== pop_exp) begin
        n_err++; $display("FAIL hold_release[%0d] got %h want %h", i, pop_obs, pop_exp);
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h0000_B001, 32'h0000_0300, 8'h00, Hold_None, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_B002, 32'h0000_0304, 8'h00, Hold_None, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_B003, 32'h0000_0308, 8'h00, Hold_None, 1'b1, 1'b1);
    n_vec++;
    if ({out_valid_o, in_ready_o, inst_o} !== {2'b01, 32'h0000_0001}) begin
      n_err++; $display("FAIL flush_empty got v=%b r=%b inst=%h want v=0 r=1 inst=00000001",
                        out_valid_o, in_ready_o, inst_o);
    end
    cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_None, 1'b0, 1'b1);
    n_vec++;
    if ({out_valid_o, inst_o, inst_addr_o, int_flag_o} !== {1'b0, IDLE_HEAD}) begin
      n_err++; $display("FAIL flush_dropped got v=%b %h want v=0 %h", out_valid_o,
                        {inst_o, inst_addr_o, int_flag_o}, IDLE_HEAD);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_bubble;
    logic [31:0] exp_stall;
`ifdef IF_ID_PERF_EN
    exp_bubble = 32'd5;
    exp_stall  = 32'd3;
`else
    exp_bubble = 32'd0;
    exp_stall  = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h0000_C000 + 32'(i), 32'h0, 8'h0, Hold_If, 1'b0, 1'b0);
    end
    cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_If, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 8'h0, Hold_None, 1'b0, 1'b0);
    end
    n_vec++;
    if (bubble_cnt_o !== exp_bubble) begin
      n_err++; $display("FAIL perf_bubble got %0d want %0d", bubble_cnt_o, exp_bubble);
    end
    n_vec++;
    if (stall_cnt_o !== exp_stall) begin
      n_err++; $display("FAIL perf_stall got %0d want %0d", stall_cnt_o, exp_stall);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_stream();
    test_hold();
    test_flush();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
